obu_framer: RTL and testbench

Byte-stream front end for `obu_parser`. It parses each AV1 OBU header (header byte, optional extension byte, LEB128 `obu_size`) and reports type and size. It packs the payload MSB-first into `PARSER_DATA_WIDTH`-bit words with `start`/`last`/`last_len` framing, and buffers them in a small FIFO that `obu_parser` drains through `avail`/`pop`.

---
 rtl/obu_framer_if.sv | 27 ++
 rtl/obu_framer.sv | 259 +++++++++++++++++++++++++
 tb/tb_obu_framer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obu_framer_if.sv
// Byte-in / word-out bundle for obu_framer.
// The framer connects through the slave modport, the byte source and word consumer through master.
interface obu_framer_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data;
  logic        avail;
  logic        start;
  logic        last;
  logic [4:0]  last_len;
  logic        pop;
  logic        hdr_valid;
  logic [3:0]  obu_type;
  logic [31:0] obu_size;
  logic        err;

  modport master (
    output in_byte, in_valid, pop,
    input  in_ready, data, avail, start, last, last_len, hdr_valid, obu_type, obu_size, err
  );

  modport slave (
    input  in_byte, in_valid, pop,
    output in_ready, data, avail, start, last, last_len, hdr_valid, obu_type, obu_size, err
  );
endinterface

// File: rtl/obu_framer.sv
// obu_framer: AV1 OBU header/LEB128 size parser that packs payload bytes MSB-first into a word FIFO.
// Define OBU_FRAMER_DROP_EN to discard payloads of OBU types other than 1, 3, 4 and 6.
module obu_framer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  obu_framer_if.slave bus
);
  localparam int PARSER_DATA_WIDTH = 32;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_EXT     = 3'd1,
    ST_SIZE    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DROP    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  typedef struct packed {
    logic [PARSER_DATA_WIDTH-1:0] data;
    logic                         start;
    logic                         last;
    logic [4:0]                   last_len;
  } entry_t;

  state_e                       state_q, state_d;
  logic [3:0]                   hdr_type_q, hdr_type_d;
  logic [31:0]                  size_acc_q, size_acc_d;
  logic [2:0]                   size_idx_q, size_idx_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic [PARSER_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [1:0]                   pack_n_q, pack_n_d;
  logic                         first_q, first_d;
  logic [3:0]                   obu_type_q, obu_type_d;
  logic [31:0]                  obu_size_q, obu_size_d;
  logic                         hdr_valid_q, hdr_valid_d;
  logic                         err_q, err_d;
  entry_t                       mem_q [FIFO_DEPTH];
  entry_t                       mem_d [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;

  logic [7:0]                   b_s;
  logic                         full_s;
  logic                         avail_s;
  logic                         in_ready_s;
  logic                         accept_s;
  logic                         pop_s;
  logic                         push_s;
  entry_t                       push_entry_s;
  logic [5:0]                   shamt_s;
  logic [31:0]                  contrib_s;
  logic [31:0]                  size_new_s;
  logic                         keep_s;
  logic [PARSER_DATA_WIDTH-1:0] pack_word_s;
  logic                         final_s;

  assign b_s        = bus.in_byte;
  assign full_s     = (count_q == FULL_CNT);
  assign avail_s    = (count_q != {CW{1'b0}});
  assign in_ready_s = !((state_q == ST_PAYLOAD) && full_s);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign pop_s      = bus.pop && avail_s;

  // LEB128: byte i contributes its low seven bits at bit position 7*i
  assign shamt_s    = {3'd0, size_idx_q} * 6'd7;
  assign contrib_s  = {25'd0, b_s[6:0]} << shamt_s;
  assign size_new_s = size_acc_q | contrib_s;

  assign pack_word_s = pack_q | ({b_s, 24'd0} >> {pack_n_q, 3'b000});
  assign final_s     = (cnt_q == 32'd1);

`ifdef OBU_FRAMER_DROP_EN
  assign keep_s = (hdr_type_q == 4'd1) || (hdr_type_q == 4'd3) ||
                  (hdr_type_q == 4'd4) || (hdr_type_q == 4'd6);
`else
  assign keep_s = 1'b1;
`endif

  // Parser next-state, header reporting and payload packing
  always_comb begin
    state_d      = state_q;
    hdr_type_d   = hdr_type_q;
    size_acc_d   = size_acc_q;
    size_idx_d   = size_idx_q;
    cnt_d        = cnt_q;
    pack_d       = pack_q;
    pack_n_d     = pack_n_q;
    first_d      = first_q;
    obu_type_d   = obu_type_q;
    obu_size_d   = obu_size_q;
    hdr_valid_d  = 1'b0;
    err_d        = err_q;
    push_s       = 1'b0;
    push_entry_s = '0;

    case (state_q)
      ST_HDR: begin
        if (accept_s) begin
          if (b_s[7] || !b_s[1]) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            hdr_type_d = b_s[6:3];
            size_acc_d = 32'd0;
            size_idx_d = 3'd0;
            state_d    = b_s[2] ? ST_EXT : ST_SIZE;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_EXT: begin
        if (accept_s) begin
          state_d = ST_SIZE;
        end else begin
          state_d = ST_EXT;
        end
      end
      ST_SIZE: begin
        if (accept_s) begin
          // a sixth byte, or a fifth byte carrying bits beyond 2^32, is malformed
          if ((size_idx_q == 3'd5) || ((size_idx_q == 3'd4) && (b_s[6:4] != 3'd0))) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (b_s[7]) begin
            size_acc_d = size_new_s;
            size_idx_d = size_idx_q + 3'd1;
          end else begin
            hdr_valid_d = 1'b1;
            obu_type_d  = hdr_type_q;
            obu_size_d  = size_new_s;
            cnt_d       = size_new_s;
            pack_d      = '0;
            pack_n_d    = 2'd0;
            first_d     = 1'b1;
            if (size_new_s == 32'd0) begin
              state_d = ST_HDR;
            end else if (keep_s) begin
              state_d = ST_PAYLOAD;
            end else begin
              state_d = ST_DROP;
            end
          end
        end else begin
          state_d = ST_SIZE;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          cnt_d = cnt_q - 32'd1;
          if ((pack_n_q == 2'd3) || final_s) begin
            push_s                = 1'b1;
            push_entry_s.data     = pack_word_s;
            push_entry_s.start    = first_q;
            push_entry_s.last     = final_s;
            push_entry_s.last_len = final_s ? {pack_n_q + 2'd1, 3'b000} : 5'd0;
            pack_d                = '0;
            pack_n_d              = 2'd0;
            first_d               = 1'b0;
          end else begin
            pack_d   = pack_word_s;
            pack_n_d = pack_n_q + 2'd1;
          end
          state_d = final_s ? ST_HDR : ST_PAYLOAD;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (accept_s) begin
          cnt_d   = cnt_q - 32'd1;
          state_d = final_s ? ST_HDR : ST_DROP;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // FIFO storage and pointer updates
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_entry_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_s};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_s};
    count_d  = count_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HDR;
      hdr_type_q  <= 4'd0;
      size_acc_q  <= 32'd0;
      size_idx_q  <= 3'd0;
      cnt_q       <= 32'd0;
      pack_q      <= '0;
      pack_n_q    <= 2'd0;
      first_q     <= 1'b0;
      obu_type_q  <= 4'd0;
      obu_size_q  <= 32'd0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hdr_type_q  <= hdr_type_d;
      size_acc_q  <= size_acc_d;
      size_idx_q  <= size_idx_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      pack_n_q    <= pack_n_d;
      first_q     <= first_d;
      obu_type_q  <= obu_type_d;
      obu_size_q  <= obu_size_d;
      hdr_valid_q <= hdr_valid_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.avail     = avail_s;
  assign bus.data      = mem_q[rd_ptr_q].data;
  assign bus.start     = avail_s && mem_q[rd_ptr_q].start;
  assign bus.last      = avail_s && mem_q[rd_ptr_q].last;
  assign bus.last_len  = mem_q[rd_ptr_q].last_len;
  assign bus.hdr_valid = hdr_valid_q;
  assign bus.obu_type  = obu_type_q;
  assign bus.obu_size  = obu_size_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_obu_framer.sv
// Scoreboard bench for obu_framer: expected headers and words are queued as bytes are driven
// and compared when the DUT pulses hdr_valid or a word is popped.
module tb_obu_framer;
  typedef struct packed {
    logic [31:0] data;
    logic        start;
    logic        last;
    logic [4:0]  len;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obu_framer_if bus();
  obu_framer #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  word_t       exp_words[$];
  logic [35:0] exp_hdrs[$];
  int          checks = 0;
  int          fails  = 0;
  word_t       mw;
  logic [35:0] mh;

  // Output monitor: popped words and header pulses against the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.avail && bus.pop) begin
      checks++;
      if (exp_words.size() == 0) begin
        fails++;
        $display("FAIL word_unexpected: got %h start=%b last=%b len=%0d, none expected",
                 bus.data, bus.start, bus.last, bus.last_len);
      end else begin
        mw = exp_words.pop_front();
        if ({bus.data, bus.start, bus.last, bus.last_len} !== mw) begin
          fails++;
          $display("FAIL word: got %h/%b/%b/%0d exp %h/%b/%b/%0d", bus.data, bus.start, bus.last,
                   bus.last_len, mw.data, mw.start, mw.last, mw.len);
        end
      end
    end
    if (!rst && bus.hdr_valid) begin
      checks++;
      if (exp_hdrs.size() == 0) begin
        fails++;
        $display("FAIL hdr_unexpected: got type %0d size %0d", bus.obu_type, bus.obu_size);
      end else begin
        mh = exp_hdrs.pop_front();
        if ({bus.obu_type, bus.obu_size} !== mh) begin
          fails++;
          $display("FAIL hdr: got type %0d size %0d exp type %0d size %0d",
                   bus.obu_type, bus.obu_size, mh[35:32], mh[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the byte
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, w);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_obu(input logic [7:0] pay[$], input logic [3:0] typ, input logic fwd);
    word_t w;
    int    n = pay.size();
    exp_hdrs.push_back({typ, 32'(n)});
    if (fwd) begin
      w = '0;
      for (int i = 0; i < n; i++) begin
        w.data[31 - 8*(i % 4) -: 8] = pay[i];
        if ((i % 4 == 3) || (i == n - 1)) begin
          w.start = (i < 4);
          w.last  = (i == n - 1);
          w.len   = (i == n - 1) ? 5'(8 * (n % 4)) : 5'd0;
          exp_words.push_back(w);
          w = '0;
        end
      end
    end
  endtask

  task automatic send_obu(input logic [7:0] hdr[$], input logic [7:0] pay[$],
                          input logic [3:0] typ, input logic fwd);
    expect_obu(pay, typ, fwd);
    foreach (hdr[i]) send_byte(hdr[i]);
    foreach (pay[i]) send_byte(pay[i]);
  endtask

  task automatic drain();
    int w = 0;
    bus.pop = 1'b1;
    while (exp_words.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.pop      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.avail, bus.start, bus.last, bus.hdr_valid, bus.err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_flags: got rdy/av/st/la/hv/err=%b%b%b%b%b%b exp 100000", bus.in_ready,
               bus.avail, bus.start, bus.last, bus.hdr_valid, bus.err);
    end
    checks++;
    if ({bus.data, bus.last_len, bus.obu_type, bus.obu_size} !== 73'd0) begin
      fails++;
      $display("FAIL reset_values: got data %h len %0d type %0d size %0d exp all 0",
               bus.data, bus.last_len, bus.obu_type, bus.obu_size);
    end
    sync();
  endtask

  task automatic test_basic();
    logic [7:0] pay[$];
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    bus.pop = 1'b1;
    expect_obu(pay, 4'd1, 1'b1);
    send_byte(8'h0A);
    send_byte(8'h05);
    @(negedge clk);
    checks++;
    if ({bus.hdr_valid, bus.obu_type, bus.obu_size} !== {1'b1, 4'd1, 32'd5}) begin
      fails++;
      $display("FAIL basic_hdr_timing: got hv=%b type %0d size %0d exp hv=1 type 1 size 5",
               bus.hdr_valid, bus.obu_type, bus.obu_size);
    end
    sync();
    foreach (pay[i]) send_byte(pay[i]);
    @(negedge clk);
    checks++;
    if ({bus.hdr_valid, bus.obu_type, bus.obu_size} !== {1'b0, 4'd1, 32'd5}) begin
      fails++;
      $display("FAIL basic_hdr_hold: got hv=%b type %0d size %0d exp hv=0 type 1 size 5",
               bus.hdr_valid, bus.obu_type, bus.obu_size);
    end
    sync();
    drain();
    checks++;
    if (exp_words.size() + exp_hdrs.size() !== 0) begin
      fails++;
      $display("FAIL basic_drain: got %0d pending exp 0", exp_words.size() + exp_hdrs.size());
    end
  endtask

  task automatic test_zero_size();
    logic [7:0] hdr[$];
    logic [7:0] pay[$];
    bus.pop = 1'b1;
    hdr = '{8'h12, 8'h00};
    pay.delete();
    send_obu(hdr, pay, 4'd2, 1'b1);
    hdr = '{8'h0A, 8'h01};
    pay = '{8'h77};
    send_obu(hdr, pay, 4'd1, 1'b1);
    drain();
    checks++;
    if (exp_words.size() + exp_hdrs.size() !== 0) begin
      fails++;
      $display("FAIL zero_drain: got %0d pending exp 0", exp_words.size() + exp_hdrs.size());
    end
  endtask

  task automatic test_ext_long();
    logic [7:0] hdr[$];
    logic [7:0] pay[$];
    bus.pop = 1'b1;
    hdr = '{8'h1E, 8'h00, 8'h80, 8'h01};
    pay.delete();
    for (int i = 0; i < 128; i++) pay.push_back(8'(i) ^ 8'h5A);
    send_obu(hdr, pay, 4'd3, 1'b1);
    drain();
    checks++;
    if (exp_words.size() + exp_hdrs.size() !== 0) begin
      fails++;
      $display("FAIL ext_drain: got %0d pending exp 0", exp_words.size() + exp_hdrs.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pay[$];
    bus.pop = 1'b0;
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'(8'h30 + i));
    expect_obu(pay, 4'd1, 1'b1);
    send_byte(8'h0A);
    send_byte(8'h14);
    for (int i = 0; i < 3; i++) send_byte(pay[i]);
    @(negedge clk);
    checks++;
    if (bus.avail !== 1'b0) begin
      fails++;
      $display("FAIL bp_avail_early: got %b exp 0", bus.avail);
    end
    sync();
    send_byte(pay[3]);
    @(negedge clk);
    checks++;
    if ({bus.avail, bus.start, bus.data} !== {1'b1, 1'b1, 32'h30313233}) begin
      fails++;
      $display("FAIL bp_first_word: got avail=%b start=%b data %h exp 1 1 30313233",
               bus.avail, bus.start, bus.data);
    end
    sync();
    for (int i = 4; i < 16; i++) send_byte(pay[i]);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_full_ready: got %b exp 0", bus.in_ready);
    end
    sync();
    bus.pop = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_ready_before_pop: got %b exp 0", bus.in_ready);
    end
    sync();
    bus.pop = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready_after_pop: got %b exp 1", bus.in_ready);
    end
    sync();
    for (int i = 16; i < 20; i++) send_byte(pay[i]);
    drain();
    checks++;
    if (exp_words.size() + exp_hdrs.size() !== 0) begin
      fails++;
      $display("FAIL bp_drain: got %0d pending exp 0", exp_words.size() + exp_hdrs.size());
    end
  endtask

  task automatic test_err();
    logic [7:0] hdr[$];
    logic [7:0] pay[$];
    bus.pop = 1'b1;
    send_byte(8'h80);
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got %b exp 1", bus.err);
    end
    sync();
    send_byte(8'h0A);
    send_byte(8'h01);
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.err, bus.avail} !== 2'b10) begin
      fails++;
      $display("FAIL err_sticky: got err=%b avail=%b exp 1 0", bus.err, bus.avail);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got %b exp 0", bus.err);
    end
    sync();
    bus.pop = 1'b1;
    hdr = '{8'h0A, 8'h80, 8'h80, 8'h80, 8'h80, 8'h10};
    foreach (hdr[i]) send_byte(hdr[i]);
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      fails++;
      $display("FAIL err_leb_overflow: got %b exp 1", bus.err);
    end
    apply_reset();
    bus.pop = 1'b1;
    hdr = '{8'h0A, 8'h01};
    pay = '{8'h55};
    send_obu(hdr, pay, 4'd1, 1'b1);
    drain();
    checks++;
    if ({bus.err, 32'(exp_words.size() + exp_hdrs.size())} !== 33'd0) begin
      fails++;
      $display("FAIL err_recover: got err=%b pending %0d exp 0 0", bus.err,
               exp_words.size() + exp_hdrs.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] hdr[$];
    logic [7:0] pay[$];
    bus.pop = 1'b0;
    exp_hdrs.push_back({4'd1, 32'd5});
    send_byte(8'h0A);
    send_byte(8'h05);
    send_byte(8'hAA);
    send_byte(8'hBB);
    apply_reset();
    @(negedge clk);
    checks++;
    if ({bus.avail, bus.in_ready, 32'(exp_hdrs.size())} !== {1'b0, 1'b1, 32'd0}) begin
      fails++;
      $display("FAIL mid_reset: got avail=%b rdy=%b hdr pending %0d exp 0 1 0",
               bus.avail, bus.in_ready, exp_hdrs.size());
    end
    sync();
    bus.pop = 1'b1;
    hdr = '{8'h22, 8'h03};
    pay = '{8'hC1, 8'hC2, 8'hC3};
    send_obu(hdr, pay, 4'd4, 1'b1);
    drain();
    checks++;
    if (exp_words.size() + exp_hdrs.size() !== 0) begin
      fails++;
      $display("FAIL mid_drain: got %0d pending exp 0", exp_words.size() + exp_hdrs.size());
    end
  endtask

`ifdef OBU_FRAMER_DROP_EN
  task automatic test_drop();
    logic [7:0] hdr[$];
    logic [7:0] pay[$];
    bus.pop = 1'b1;
    hdr = '{8'h7A, 8'h03};
    pay = '{8'h11, 8'h22, 8'h33};
    send_obu(hdr, pay, 4'd15, 1'b0);
    hdr = '{8'h0A, 8'h01};
    pay = '{8'h99};
    send_obu(hdr, pay, 4'd1, 1'b1);
    drain();
    checks++;
    if (exp_words.size() + exp_hdrs.size() !== 0) begin
      fails++;
      $display("FAIL drop_drain: got %0d pending exp 0", exp_words.size() + exp_hdrs.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_size();
    test_ext_long();
    test_back_to_back();
    test_err();
    test_reset_mid();
`ifdef OBU_FRAMER_DROP_EN
    test_drop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
